// File: rtl/atmos_light_est.sv
// atmos_light_est
//
// Estimates atmospheric light from a dark-channel video stream: tracks the
// brightest valid pixel of each frame and commits it as A_value when the
// frame ends. The video stream is forwarded to the post_* outputs with one
// register stage.
//
// Optional feature: define ATMOS_SMOOTH_EN to blend each new frame maximum
// into the previous A_value (3:1 temporal IIR) instead of using it directly.
//
// Ports
//   clk                 sole clock, rising edge
//   rst                 synchronous, active-high reset
//   pre_frame_vsync     frame-active qualifier (high for the whole frame)
//   pre_frame_href      line-active qualifier
//   pre_frame_clken     pixel-valid strobe
//   pre_img[7:0]        dark-channel pixel
//   post_frame_*        pre_frame_* delayed by one cycle
//   post_img[7:0]       pre_img delayed by one cycle
//   A_value[7:0]        atmospheric light estimate, changes only at a commit
//   a_update            one-cycle pulse when a new A_value first appears
//   a_locked            high once at least one frame has been committed

module atmos_light_est #(
    parameter logic [7:0] A_INIT = 8'd255,
    parameter logic [7:0] A_MIN  = 8'd64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pre_frame_vsync,
    input  logic       pre_frame_href,
    input  logic       pre_frame_clken,
    input  logic [7:0] pre_img,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic       post_frame_clken,
    output logic [7:0] post_img,
    output logic [7:0] A_value,
    output logic       a_update,
    output logic       a_locked
);

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StUpdate
    } state_e;

    state_e      state_q;
    logic        vsync_prev_q;
    logic        post_vsync_q;
    logic        post_href_q;
    logic        post_clken_q;
    logic [7:0]  post_img_q;
    logic [7:0]  frame_max_q;
    logic [21:0] pix_cnt_q;
    logic [7:0]  a_value_q;
    logic        a_update_q;
    logic        a_locked_q;

    logic        pix_valid;
    logic        vsync_rise;
    logic        vsync_fall;
    logic [7:0]  candidate;
    logic [7:0]  commit_val;

    assign pix_valid  = pre_frame_vsync & pre_frame_href & pre_frame_clken;
    assign vsync_rise = ~vsync_prev_q & pre_frame_vsync;
    assign vsync_fall = vsync_prev_q & ~pre_frame_vsync;

`ifdef ATMOS_SMOOTH_EN
    logic [9:0] iir_sum;

    // 3*A + max + 2 peaks at 1022, so 10 bits never overflow.
    assign iir_sum = ({2'b00, a_value_q} << 1) + {2'b00, a_value_q}
                   + {2'b00, frame_max_q} + 10'd2;

    // Nothing to blend with before the first commit: take the frame maximum.
    assign candidate = a_locked_q ? iir_sum[9:2] : frame_max_q;
`else
    assign candidate = frame_max_q;
`endif

    // Clamp keeps the downstream divisor away from zero.
    assign commit_val = (candidate < A_MIN) ? A_MIN : candidate;

    // Edge-detect register is not cleared by reset: it follows the input so
    // that a vsync already high at reset release is not seen as a new frame.
    always_ff @(posedge clk) begin
        vsync_prev_q <= pre_frame_vsync;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            post_vsync_q <= 1'b0;
            post_href_q  <= 1'b0;
            post_clken_q <= 1'b0;
            post_img_q   <= 8'd0;
        end else begin
            post_vsync_q <= pre_frame_vsync;
            post_href_q  <= pre_frame_href;
            post_clken_q <= pre_frame_clken;
            post_img_q   <= pre_img;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            frame_max_q <= 8'd0;
            pix_cnt_q   <= 22'd0;
            a_value_q   <= A_INIT;
            a_update_q  <= 1'b0;
            a_locked_q  <= 1'b0;
        end else begin
            a_update_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (vsync_rise) begin
                        state_q     <= StActive;
                        frame_max_q <= 8'd0;
                        pix_cnt_q   <= 22'd0;
                    end
                end
                StActive: begin
                    if (vsync_fall) begin
                        state_q <= StUpdate;
                    end else if (pix_valid) begin
                        if (pre_img > frame_max_q) begin
                            frame_max_q <= pre_img;
                        end
                        if (pix_cnt_q != '1) begin
                            pix_cnt_q <= pix_cnt_q + 22'd1;
                        end
                    end
                end
                StUpdate: begin
                    // A frame with no valid pixels leaves the estimate alone.
                    if (pix_cnt_q != 22'd0) begin
                        a_value_q  <= commit_val;
                        a_update_q <= 1'b1;
                        a_locked_q <= 1'b1;
                    end
                    // Back-to-back frame: vsync already high again.
                    if (pre_frame_vsync) begin
                        state_q     <= StActive;
                        frame_max_q <= 8'd0;
                        pix_cnt_q   <= 22'd0;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign post_frame_vsync = post_vsync_q;
    assign post_frame_href  = post_href_q;
    assign post_frame_clken = post_clken_q;
    assign post_img         = post_img_q;
    assign A_value          = a_value_q;
    assign a_update         = a_update_q;
    assign a_locked         = a_locked_q;

endmodule

// File: tb/tb_atmos_light_est.sv
// Self-checking bench for atmos_light_est: directed frames with literal
// expectations plus randomized frames checked every cycle against a
// frame-level reference model.

module tb_atmos_light_est;

    localparam logic [7:0] AINIT = 8'd255;
    localparam logic [7:0] AMIN  = 8'd64;

    logic       clk = 1'b0;
    logic       rst;
    logic       vs;
    logic       hr;
    logic       ce;
    logic [7:0] img;
    logic       p_vs;
    logic       p_hr;
    logic       p_ce;
    logic [7:0] p_img;
    logic [7:0] a_val;
    logic       a_upd;
    logic       a_lock;

    always #5 clk = ~clk;

    atmos_light_est #(
        .A_INIT(AINIT),
        .A_MIN (AMIN)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pre_frame_vsync (vs),
        .pre_frame_href  (hr),
        .pre_frame_clken (ce),
        .pre_img         (img),
        .post_frame_vsync(p_vs),
        .post_frame_href (p_hr),
        .post_frame_clken(p_ce),
        .post_img        (p_img),
        .A_value         (a_val),
        .a_update        (a_upd),
        .a_locked        (a_lock)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Works at frame granularity: a frame opens on a vsync rise, collects
    // the maximum of valid pixels while vsync stays high, and its result is
    // committed on the second clock edge after vsync is seen low.
    logic       m_valid = 1'b0;
    logic       m_pvs, m_phr, m_pce;
    logic [7:0] m_pimg;
    logic [7:0] m_a;
    logic       m_upd, m_lock;
    logic       m_prev, m_open, m_pend, m_any;
    logic [7:0] m_max;
    logic [7:0] upd_q[$];

    task automatic model_step();
        int c;
        if (rst) begin
            {m_pvs, m_phr, m_pce} = 3'b000;
            m_pimg  = 8'd0;
            m_a     = AINIT;
            m_upd   = 1'b0;
            m_lock  = 1'b0;
            m_open  = 1'b0;
            m_pend  = 1'b0;
            m_any   = 1'b0;
            m_max   = 8'd0;
            m_prev  = vs;
            m_valid = 1'b1;
        end else begin
            {m_pvs, m_phr, m_pce} = {vs, hr, ce};
            m_pimg = img;
            m_upd  = 1'b0;
            if (m_pend) begin
                m_pend = 1'b0;
                if (m_any) begin
`ifdef ATMOS_SMOOTH_EN
                    c = m_lock ? (3 * int'(m_a) + int'(m_max) + 2) / 4 : int'(m_max);
`else
                    c = int'(m_max);
`endif
                    if (c < int'(AMIN)) c = int'(AMIN);
                    m_a    = c[7:0];
                    m_upd  = 1'b1;
                    m_lock = 1'b1;
                end
                if (vs) begin
                    m_open = 1'b1;
                    m_max  = 8'd0;
                    m_any  = 1'b0;
                end
            end else if (m_open) begin
                if (!vs) begin
                    m_open = 1'b0;
                    m_pend = 1'b1;
                end else if (hr && ce) begin
                    if (img > m_max) m_max = img;
                    m_any = 1'b1;
                end
            end else if (!m_prev && vs) begin
                m_open = 1'b1;
                m_max  = 8'd0;
                m_any  = 1'b0;
            end
            m_prev = vs;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Compare on the falling edge, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            chk("post_vsync", {31'd0, p_vs}, {31'd0, m_pvs});
            chk("post_href",  {31'd0, p_hr}, {31'd0, m_phr});
            chk("post_clken", {31'd0, p_ce}, {31'd0, m_pce});
            chk("post_img",   {24'd0, p_img}, {24'd0, m_pimg});
            chk("A_value",    {24'd0, a_val}, {24'd0, m_a});
            chk("a_update",   {31'd0, a_upd}, {31'd0, m_upd});
            chk("a_locked",   {31'd0, a_lock}, {31'd0, m_lock});
            if (a_upd === 1'b1) upd_q.push_back(a_val);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        vs = 1'b0; hr = 1'b0; ce = 1'b0;
        repeat (n) step();
    endtask

    // Drives a frame of lines of 4 pixels, then one vsync-low cycle.
    // Returns just after the edge that first samples vsync low.
    task automatic frame_px(input logic [7:0] px[$]);
        vs = 1'b1; hr = 1'b0; ce = 1'b0;
        step();
        foreach (px[i]) begin
            if (i != 0 && i % 4 == 0) begin
                hr = 1'b0; ce = 1'b0;
                step();
            end
            hr = 1'b1; ce = 1'b1; img = px[i];
            step();
        end
        hr = 1'b0; ce = 1'b0;
        step();
        vs = 1'b0;
        step();
    endtask

    task automatic const_frame(input logic [7:0] peak, input logic [7:0] fill);
        logic [7:0] px[$];
        for (int i = 0; i < 8; i++) px.push_back((i == 5) ? peak : fill);
        frame_px(px);
    endtask

    initial begin
        logic [7:0] px[$];
        rst = 1'b1; vs = 1'b0; hr = 1'b0; ce = 1'b0; img = 8'd0;
        step();
        step();
        chk("reset A_value", {24'd0, a_val}, 32'd255);
        chk("reset a_locked", {31'd0, a_lock}, 32'd0);
        chk("reset post_vsync", {31'd0, p_vs}, 32'd0);
        rst = 1'b0;
        idle(2);

        // Pass-through with a known pixel outside any frame.
        hr = 1'b1; ce = 1'b1; img = 8'hA5;
        step();
        chk("pass post_img", {24'd0, p_img}, 32'hA5);
        chk("pass post_href", {31'd0, p_hr}, 32'd1);
        idle(2);

        // Frame with href never high: nothing committed.
        upd_q.delete();
        vs = 1'b1;
        repeat (5) step();
        idle(4);
        chk("empty A_value", {24'd0, a_val}, 32'd255);
        chk("empty a_locked", {31'd0, a_lock}, 32'd0);
        chk("empty updates", upd_q.size(), 32'd0);

        // 4x4 frame, pixels spread over 10..200, commit latency checked.
        for (int i = 0; i < 16; i++) px.push_back(8'(10 + ((i * 7) % 16) * 190 / 15));
        frame_px(px);
        chk("lat A before", {24'd0, a_val}, 32'd255);
        chk("lat upd before", {31'd0, a_upd}, 32'd0);
        step();
        chk("lat A commit", {24'd0, a_val}, 32'd200);
        chk("lat upd pulse", {31'd0, a_upd}, 32'd1);
        step();
        chk("lat upd after", {31'd0, a_upd}, 32'd0);
        chk("lat a_locked", {31'd0, a_lock}, 32'd1);
        idle(3);

`ifdef ATMOS_SMOOTH_EN
        const_frame(8'd100, 8'd30);
        idle(3);
        chk("smooth A_value", {24'd0, a_val}, 32'd175);
`else
        const_frame(8'd20, 8'd20);
        idle(3);
        chk("clamp A_value", {24'd0, a_val}, 32'd64);

        // Back-to-back frames with a single vsync-low cycle between them.
        upd_q.delete();
        const_frame(8'd180, 8'd50);
        const_frame(8'd90, 8'd40);
        idle(4);
        chk("b2b count", upd_q.size(), 32'd2);
        if (upd_q.size() == 2) begin
            chk("b2b first", {24'd0, upd_q[0]}, 32'd180);
            chk("b2b second", {24'd0, upd_q[1]}, 32'd90);
        end
`endif

        // Reset mid-frame with vsync held high: partial frame discarded.
        upd_q.delete();
        vs = 1'b1; hr = 1'b0; ce = 1'b0;
        step();
        hr = 1'b1; ce = 1'b1;
        img = 8'd100; step();
        img = 8'd250; step();
        rst = 1'b1; step();
        rst = 1'b0;
        img = 8'd90; step();
        img = 8'd30; step();
        idle(4);
        chk("rst A_value", {24'd0, a_val}, 32'd255);
        chk("rst a_locked", {31'd0, a_lock}, 32'd0);
        chk("rst updates", upd_q.size(), 32'd0);
        const_frame(8'd120, 8'd70);
        idle(3);
        chk("post-rst A_value", {24'd0, a_val}, 32'd120);
        chk("post-rst a_locked", {31'd0, a_lock}, 32'd1);

        // Randomized frames, checked every cycle by the model.
        for (int f = 0; f < 300; f++) begin
            int gap;
            int len;
            int rst_at;
            gap    = $urandom_range(1, 3);
            len    = $urandom_range(0, 30);
            rst_at = ($urandom_range(0, 24) == 0) ? $urandom_range(0, 30) : -1;
            vs = 1'b0;
            for (int g = 0; g < gap; g++) begin
                hr = 1'($urandom); ce = 1'($urandom); img = 8'($urandom);
                step();
            end
            vs = 1'b1; hr = 1'b0; ce = 1'b0; img = 8'($urandom);
            step();
            for (int k = 0; k < len; k++) begin
                rst = (k == rst_at);
                hr  = ($urandom_range(0, 3) != 0);
                ce  = 1'($urandom);
                img = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 80))
                                                  : 8'($urandom);
                step();
            end
            rst = 1'b0;
        end
        idle(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
